snes_poll_scheduler: RTL and testbench
======================================

// Module: snes_poll_scheduler
// PURPOSE
//  Sequences serial reads of two SNES pads sharing one LATCH/PULSE bus, each with its own DATA line.
//  Starts a poll on a free-running frame timer or on a REQ strobe from the CPU/APU side.
//  Publishes both 16-bit button words atomically, with a one-cycle VALID pulse.
//  Sits between the pad connector pins and the NES register-file joypad logic.
// PARAMETERS
//  HALF_CYCLES  300     CLOCK cycles per half bit-period (6 us at 50 MHz); legal range >= 4
//  POLL_PERIOD  833333  CLOCK cycles between timer-triggered polls (60 Hz at 50 MHz); must exceed 34*HALF_CYCLES+1
//  NUM_BITS     16      serial bits shifted per pad per poll
// PORTS
//  CLOCK     in   1         system clock; all logic on rising edge
//  RESET     in   1         asynchronous, active-high reset
//  REQ       in   1         one-cycle poll request
//  DATA1     in   1         pad 1 serial data, active-low, asynchronous to CLOCK
//  DATA2     in   1         pad 2 serial data, active-low, asynchronous to CLOCK
//  LATCH     out  1         shared latch to pads, active-high
//  PULSE     out  1         shared shift clock to pads; idles high
//  BUSY      out  1         high from the LATCH state through the DONE state
//  VALID     out  1         one-cycle strobe: BUTTONS1/2 updated this cycle
//  BUTTONS1  out  NUM_BITS  pad 1 buttons, active-high; [0]=first bit shifted (B)
//  BUTTONS2  out  NUM_BITS  pad 2 buttons, same bit order as BUTTONS1
// BEHAVIOUR
//  Reset values: LATCH=0, PULSE=1, BUSY=0, VALID=0, BUTTONS1=BUTTONS2=0.
//  Reset also clears state (IDLE), pending flag, timer, bit counter and phase counter.
//  RESET mid-poll aborts immediately. Partial shift data is discarded; BUTTONS keep 0.
//  DATA1/DATA2 each pass a 2-FF synchronizer. All sampling uses the synchronized value.
//  Timer: counts 0..POLL_PERIOD-1 continuously from reset release, independent of state.
//  Timer tick: one cycle when the count wraps to 0.
//  Pending flag: set by a tick or by REQ; cleared when IDLE launches a poll.
//    One-deep: any number of ticks/REQs during a poll yields exactly one follow-up poll.
//    A tick and REQ in the same cycle count as one request.
//  FSM:
//    IDLE:   LATCH=0, PULSE=1. Goes to LATCH when pending is set or REQ/tick is asserted this cycle.
//    LATCH:  LATCH=1 for 2*HALF_CYCLES cycles -> HIGH.
//    HIGH:   PULSE=1 for HALF_CYCLES cycles.
//            On the last cycle, shift in ~sync(DATA1) to bit[i] of shadow1, and likewise for pad 2 -> LOW.
//    LOW:    PULSE=0 for HALF_CYCLES cycles.
//            If i==NUM_BITS-1 -> DONE; otherwise i<=i+1 and -> HIGH.
//    DONE:   one cycle. Copy shadow1/2 to BUTTONS1/2 and assert VALID -> IDLE.
//  Poll length: 34*HALF_CYCLES+1 cycles for NUM_BITS=16 (2H + NUM_BITS*2H + 1).
//  LATCH, PULSE, BUSY and VALID are registered; no combinational path from inputs.
//  BUTTONS never change except in the DONE cycle, so both words always come from the same poll.
//  Bit counter is $clog2(NUM_BITS) wide. Phase counter is wide enough for 2*HALF_CYCLES-1.
// TESTING
//  (Bench params: HALF_CYCLES=4, POLL_PERIOD=200, NUM_BITS=16; pad models shift on PULSE rise.)
//  1 Reset: assert RESET mid-LOW phase -> same cycle LATCH=0, PULSE=1, BUSY=0.
//    BUTTONS stay 0, and no VALID appears until the next tick.
//  2 Timer poll: pad1 image 16'h0001, pad2 image 16'h8000 -> VALID at cycle 137 after LATCH rise.
//    BUTTONS1=16'h0001 and BUTTONS2=16'h8000.
//  3 Framing: count edges during one poll -> exactly 16 PULSE falling edges.
//    LATCH is high for 8 cycles and each PULSE level lasts 4 cycles.
//  4 REQ in IDLE: pulse REQ at timer count 50 -> LATCH rises 1 cycle later.
//    The next poll starts at the following tick.
//  5 Overlap: REQ plus 3 extra REQs during BUSY -> exactly one extra poll.
//    It starts 1 cycle after the first VALID.
//  6 Simultaneous REQ and tick in IDLE -> a single poll and a single VALID.
//    All-pressed pads (DATA held 0) -> BUTTONS1=BUTTONS2=16'hFFFF.

Source files
------------

// File: rtl/snes_poll_scheduler.sv
// SNES dual-pad poll scheduler: drives the shared LATCH/PULSE bus, shifts both
// pads' serial DATA lines in parallel and publishes both button words together.
module snes_poll_scheduler #(
    parameter int unsigned HALF_CYCLES = 300,
    parameter int unsigned POLL_PERIOD = 833333,
    parameter int unsigned NUM_BITS    = 16
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                REQ,
    input  logic                DATA1,
    input  logic                DATA2,
    output logic                LATCH,
    output logic                PULSE,
    output logic                BUSY,
    output logic                VALID,
    output logic [NUM_BITS-1:0] BUTTONS1,
    output logic [NUM_BITS-1:0] BUTTONS2
);

    localparam int unsigned PH_W  = $clog2(2 * HALF_CYCLES);
    localparam int unsigned BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF_CYCLES - 1);
    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t              state_q,    state_d;
    logic [PH_W-1:0]     phase_q,    phase_d;
    logic [BIT_W-1:0]    bit_q,      bit_d;
    logic [TMR_W-1:0]    timer_q,    timer_d;
    logic                tick_q,     tick_d;
    logic                pending_q,  pending_d;
    logic                d1_meta_q,  d1_meta_d;
    logic                d1_sync_q,  d1_sync_d;
    logic                d2_meta_q,  d2_meta_d;
    logic                d2_sync_q,  d2_sync_d;
    logic [NUM_BITS-1:0] shadow1_q,  shadow1_d;
    logic [NUM_BITS-1:0] shadow2_q,  shadow2_d;
    logic [NUM_BITS-1:0] buttons1_q, buttons1_d;
    logic [NUM_BITS-1:0] buttons2_q, buttons2_d;
    logic                latch_q,    latch_d;
    logic                pulse_q,    pulse_d;
    logic                busy_q,     busy_d;
    logic                valid_q,    valid_d;
    logic                go_c;

    // A tick or REQ this cycle launches directly; otherwise the remembered request does.
    assign go_c = pending_q | REQ | tick_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shadow1_d  = shadow1_q;
        shadow2_d  = shadow2_q;
        buttons1_d = buttons1_q;
        buttons2_d = buttons2_q;
        valid_d    = 1'b0;

        d1_meta_d  = DATA1;
        d1_sync_d  = d1_meta_q;
        d2_meta_d  = DATA2;
        d2_sync_d  = d2_meta_q;

        timer_d    = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_W'(1);
        tick_d     = (timer_q == TMR_LAST);
        pending_d  = pending_q | REQ | tick_q;

        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    state_d   = S_LATCH;
                    phase_d   = '0;
                    bit_d     = '0;
                    pending_d = 1'b0;
                end
            end
            S_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = S_HIGH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_HIGH: begin
                if (phase_q == HALF_LAST) begin
                    // Pads drive active-low; store pressed as 1.
                    shadow1_d[bit_q] = ~d1_sync_q;
                    shadow2_d[bit_q] = ~d2_sync_q;
                    state_d          = S_LOW;
                    phase_d          = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_LOW: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_DONE;
                        bit_d   = '0;
                    end else begin
                        state_d = S_HIGH;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_DONE: begin
                buttons1_d = shadow1_q;
                buttons2_d = shadow2_q;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus pins follow the state being entered so they change with it.
        latch_d = (state_d == S_LATCH);
        pulse_d = (state_d != S_LOW);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any poll in progress.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            timer_q    <= '0;
            tick_q     <= 1'b0;
            pending_q  <= 1'b0;
            d1_meta_q  <= 1'b0;
            d1_sync_q  <= 1'b0;
            d2_meta_q  <= 1'b0;
            d2_sync_q  <= 1'b0;
            shadow1_q  <= '0;
            shadow2_q  <= '0;
            buttons1_q <= '0;
            buttons2_q <= '0;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            timer_q    <= timer_d;
            tick_q     <= tick_d;
            pending_q  <= pending_d;
            d1_meta_q  <= d1_meta_d;
            d1_sync_q  <= d1_sync_d;
            d2_meta_q  <= d2_meta_d;
            d2_sync_q  <= d2_sync_d;
            shadow1_q  <= shadow1_d;
            shadow2_q  <= shadow2_d;
            buttons1_q <= buttons1_d;
            buttons2_q <= buttons2_d;
            latch_q    <= latch_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign LATCH    = latch_q;
    assign PULSE    = pulse_q;
    assign BUSY     = busy_q;
    assign VALID    = valid_q;
    assign BUTTONS1 = buttons1_q;
    assign BUTTONS2 = buttons2_q;

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// Directed bench for snes_poll_scheduler with two behavioural SNES pads.
module tb_snes_poll_scheduler;

    localparam int unsigned HC = 4;
    localparam int unsigned PP = 200;
    localparam int unsigned NB = 16;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          REQ   = 1'b0;
    logic          DATA1;
    logic          DATA2;
    logic          LATCH;
    logic          PULSE;
    logic          BUSY;
    logic          VALID;
    logic [NB-1:0] BUTTONS1;
    logic [NB-1:0] BUTTONS2;

    logic [15:0]   img1 = 16'h0001;
    logic [15:0]   img2 = 16'h8000;
    int            pad_idx = 0;

    int            tcnt = 0;
    int            n_assert = 0;
    int            n_fail = 0;

    snes_poll_scheduler #(
        .HALF_CYCLES(HC),
        .POLL_PERIOD(PP),
        .NUM_BITS   (NB)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .REQ     (REQ),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .LATCH   (LATCH),
        .PULSE   (PULSE),
        .BUSY    (BUSY),
        .VALID   (VALID),
        .BUTTONS1(BUTTONS1),
        .BUTTONS2(BUTTONS2)
    );

    always #5 CLOCK = ~CLOCK;

    // Pad model: LATCH reloads the shift position, each PULSE rise advances it.
    always @(posedge LATCH or posedge PULSE) begin
        if (LATCH) pad_idx <= 0;
        else       pad_idx <= pad_idx + 1;
    end

    assign DATA1 = (pad_idx < 16) ? ~img1[pad_idx] : 1'b0;
    assign DATA2 = (pad_idx < 16) ? ~img2[pad_idx] : 1'b0;

    task automatic step();
        @(posedge CLOCK);
        #1;
        tcnt++;
    endtask

    task automatic step_to(input int t);
        while (tcnt < t) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        tcnt  = 0;
    endtask

    task automatic wait_latch(output int at, output int nvalid);
        bit found = 1'b0;
        at     = -1;
        nvalid = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (VALID === 1'b1) nvalid++;
            if (LATCH === 1'b1) begin
                at    = tcnt;
                found = 1'b1;
            end
        end
    endtask

    task automatic wait_valid(output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (VALID === 1'b1) begin
                at    = tcnt;
                found = 1'b1;
            end
        end
    endtask

    // Observes one poll from its first LATCH-high cycle up to the VALID cycle.
    task automatic run_poll(output int rel, output int falls, output int latch_cyc,
                            output int busy_cyc, output int minrun, output int maxrun);
        int   n    = 0;
        int   run  = 1;
        bit   seen = 1'b0;
        logic prev;
        prev      = PULSE;
        rel       = -1;
        falls     = 0;
        latch_cyc = (LATCH === 1'b1) ? 1 : 0;
        busy_cyc  = (BUSY === 1'b1) ? 1 : 0;
        minrun    = 9999;
        maxrun    = 0;
        while (n < 300 && rel < 0) begin
            step();
            n++;
            if (VALID === 1'b1) begin
                rel = n;
            end else begin
                if (LATCH === 1'b1) latch_cyc++;
                if (BUSY === 1'b1)  busy_cyc++;
                if (PULSE === prev) begin
                    run++;
                end else begin
                    if (seen) begin
                        if (run < minrun) minrun = run;
                        if (run > maxrun) maxrun = run;
                    end
                    if (PULSE === 1'b0) begin
                        falls++;
                        seen = 1'b1;
                    end
                    run = 1;
                end
                prev = PULSE;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, nv, rel, falls, lc, bc, mn, mx;
        bit got;

        // Reset values
        step();
        step();
        check("rst_latch",    32'(LATCH),    32'd0);
        check("rst_pulse",    32'(PULSE),    32'd1);
        check("rst_busy",     32'(BUSY),     32'd0);
        check("rst_valid",    32'(VALID),    32'd0);
        check("rst_buttons1", 32'(BUTTONS1), 32'd0);
        check("rst_buttons2", 32'(BUTTONS2), 32'd0);
        RESET = 1'b0;
        tcnt  = 0;

        // 1: reset during a LOW phase aborts the poll at once
        wait_latch(at, nv);
        check("t1_first_tick_latch", 32'(at), 32'd201);
        check("t1_no_valid_before",  32'(nv), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (PULSE === 1'b0) got = 1'b1;
        end
        check("t1_reached_low", 32'(got), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("t1_abort_latch", 32'(LATCH), 32'd0);
        check("t1_abort_pulse", 32'(PULSE), 32'd1);
        check("t1_abort_busy",  32'(BUSY),  32'd0);
        check("t1_abort_valid", 32'(VALID), 32'd0);
        step();
        RESET = 1'b0;
        tcnt  = 0;
        wait_latch(at, nv);
        check("t1_relaunch_at_tick", 32'(at),       32'd201);
        check("t1_no_valid_after",   32'(nv),       32'd0);
        check("t1_buttons1_zero",    32'(BUTTONS1), 32'd0);
        check("t1_buttons2_zero",    32'(BUTTONS2), 32'd0);

        // 2 and 3: timer-launched poll, latency, data and framing
        run_poll(rel, falls, lc, bc, mn, mx);
        check("t2_valid_latency", 32'(rel),      32'd137);
        check("t2_buttons1",      32'(BUTTONS1), 32'h0001);
        check("t2_buttons2",      32'(BUTTONS2), 32'h8000);
        check("t3_pulse_falls",   32'(falls),    32'd16);
        check("t3_latch_cycles",  32'(lc),       32'd8);
        check("t3_busy_cycles",   32'(bc),       32'd137);
        check("t3_min_level",     32'(mn),       32'd4);
        check("t3_max_level",     32'(mx),       32'd4);
        check("t3_busy_at_valid", 32'(BUSY),     32'd0);
        step();
        check("t2_valid_one_cycle", 32'(VALID),    32'd0);
        check("t2_buttons1_hold",   32'(BUTTONS1), 32'h0001);

        // 4: REQ in IDLE launches next cycle; next poll waits for the tick
        do_reset();
        img1 = 16'hA5C3;
        img2 = 16'h0F0F;
        step_to(50);
        check("t4_idle_before_req", 32'(LATCH), 32'd0);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        check("t4_latch_rise", 32'(LATCH), 32'd1);
        check("t4_busy_rise",  32'(BUSY),  32'd1);
        run_poll(rel, falls, lc, bc, mn, mx);
        check("t4_valid_latency", 32'(rel),      32'd137);
        check("t4_buttons1",      32'(BUTTONS1), 32'hA5C3);
        check("t4_buttons2",      32'(BUTTONS2), 32'h0F0F);
        wait_latch(at, nv);
        check("t4_next_at_tick", 32'(at), 32'd201);
        check("t4_no_extra",     32'(nv), 32'd0);

        // 5: several requests during BUSY collapse into one follow-up poll
        do_reset();
        img1 = 16'h1234;
        img2 = 16'hFEDC;
        step_to(70);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        check("t5_latch_rise", 32'(LATCH), 32'd1);
        step_to(80);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        step_to(120);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        step_to(180);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        wait_valid(at);
        check("t5_first_valid", 32'(at),       32'd208);
        check("t5_buttons1",    32'(BUTTONS1), 32'h1234);
        check("t5_buttons2",    32'(BUTTONS2), 32'hFEDC);
        step();
        check("t5_extra_latch", 32'(LATCH), 32'd1);
        wait_valid(at);
        check("t5_extra_valid", 32'(at), 32'd346);
        wait_latch(at, nv);
        check("t5_then_tick_only", 32'(at), 32'd401);
        check("t5_single_extra",   32'(nv), 32'd0);

        // 6: REQ coinciding with a tick gives one poll; all buttons pressed
        do_reset();
        img1 = 16'hFFFF;
        img2 = 16'hFFFF;
        step_to(200);
        check("t6_idle_at_tick", 32'(LATCH), 32'd0);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        check("t6_latch_rise", 32'(LATCH), 32'd1);
        wait_valid(at);
        check("t6_valid",    32'(at),       32'd338);
        check("t6_buttons1", 32'(BUTTONS1), 32'hFFFF);
        check("t6_buttons2", 32'(BUTTONS2), 32'hFFFF);
        wait_latch(at, nv);
        check("t6_next_at_tick", 32'(at), 32'd401);
        check("t6_single_valid", 32'(nv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
